alu_acc_seq: RTL

//  Parametrised next-generation ALU for the simple CPU datapath.
//  - Owns the accumulator register and a Z/N/C/V flag register.
//  - Accepts one operation per handshake.
//  - Adds shifts, add-with-carry and a multi-cycle shift-add multiply.
//  - Sits between the internal bus and the control unit; the control unit

---
 rtl/alu_acc_seq.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/alu_acc_seq.sv
// Accumulator ALU with Z/N/C/V flags and a multi-cycle shift-add multiply.
// One op per op_valid/op_ready handshake; done pulses on every write.
module alu_acc_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] bus,
  input  logic [3:0]       alusel,
  input  logic             op_valid,
  output logic             op_ready,
  output logic [WIDTH-1:0] ac,
  output logic [WIDTH-1:0] mul_hi,
  output logic [3:0]       flags,
  output logic             done
);

  localparam int M  = WIDTH - 1;
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [3:0] OP_PASS = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_SUB  = 4'b0010;
  localparam logic [3:0] OP_INC  = 4'b0011;
  localparam logic [3:0] OP_CLR  = 4'b0100;
  localparam logic [3:0] OP_AND  = 4'b0101;
  localparam logic [3:0] OP_OR   = 4'b0110;
  localparam logic [3:0] OP_XOR  = 4'b0111;
  localparam logic [3:0] OP_NOT  = 4'b1000;
  localparam logic [3:0] OP_SHL  = 4'b1001;
  localparam logic [3:0] OP_SHR  = 4'b1010;
  localparam logic [3:0] OP_MUL  = 4'b1011;
  localparam logic [3:0] OP_ADC  = 4'b1100;

  typedef enum logic {
    S_IDLE,
    S_MUL
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] ac_q, ac_d;
  logic [WIDTH-1:0] mul_hi_q, mul_hi_d;
  logic [3:0]       flags_q, flags_d;
  logic             done_q, done_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] p_hi_q, p_hi_d;
  logic [WIDTH-1:0] p_lo_q, p_lo_d;

  logic [WIDTH-1:0] add_b;
  logic             add_ci;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic             add_v;
  logic             sub_v;
  logic [WIDTH-1:0] alu_r;
  logic             alu_c;
  logic             alu_v;
  logic             alu_wr;

  logic [WIDTH:0]   mstep;
  logic [WIDTH-1:0] p_hi_n;
  logic [WIDTH-1:0] p_lo_n;

  assign op_ready = (state_q == S_IDLE);
  assign ac       = ac_q;
  assign mul_hi   = mul_hi_q;
  assign flags    = flags_q;
  assign done     = done_q;

  // One adder serves add, inc and add-with-carry
  always_comb begin
    add_b  = bus;
    add_ci = 1'b0;
    if (alusel == OP_INC) begin
      add_b = WIDTH'(1);
    end else if (alusel == OP_ADC) begin
      add_ci = flags_q[1];
    end
  end

  assign sum   = {1'b0, ac_q} + {1'b0, add_b}
               + {{WIDTH{1'b0}}, add_ci};
  assign diff  = {1'b0, ac_q} - {1'b0, bus};
  assign add_v = (ac_q[M] == add_b[M])
               && (sum[M] != ac_q[M]);
  assign sub_v = (ac_q[M] != bus[M])
               && (diff[M] != ac_q[M]);

  always_comb begin
    alu_r  = ac_q;
    alu_c  = 1'b0;
    alu_v  = 1'b0;
    alu_wr = 1'b1;
    unique case (alusel)
      OP_PASS: alu_r = bus;
      OP_ADD, OP_INC, OP_ADC: begin
        alu_r = sum[M:0];
        alu_c = sum[WIDTH];
        alu_v = add_v;
      end
      OP_SUB: begin
        alu_r = diff[M:0];
        alu_c = diff[WIDTH];
        alu_v = sub_v;
      end
      OP_CLR:  alu_r = '0;
      OP_AND:  alu_r = ac_q & bus;
      OP_OR:   alu_r = ac_q | bus;
      OP_XOR:  alu_r = ac_q ^ bus;
      OP_NOT:  alu_r = ~ac_q;
      OP_SHL: begin
        alu_r = {ac_q[M-1:0], 1'b0};
        alu_c = ac_q[M];
      end
      OP_SHR: begin
        alu_r = {1'b0, ac_q[M:1]};
        alu_c = ac_q[0];
      end
      default: alu_wr = 1'b0;
    endcase
  end

  // Shift-add step: add multiplicand into the high half, shift pair right
  assign mstep  = {1'b0, p_hi_q}
                + (p_lo_q[0] ? {1'b0, mcand_q} : '0);
  assign p_hi_n = mstep[WIDTH:1];
  assign p_lo_n = {mstep[0], p_lo_q[M:1]};

  always_comb begin
    state_d  = state_q;
    ac_d     = ac_q;
    mul_hi_d = mul_hi_q;
    flags_d  = flags_q;
    done_d   = 1'b0;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    p_hi_d   = p_hi_q;
    p_lo_d   = p_lo_q;
    case (state_q)
      S_IDLE: begin
        if (op_valid) begin
          if (alusel == OP_MUL) begin
            state_d = S_MUL;
            cnt_d   = '0;
            mcand_d = bus;
            p_hi_d  = '0;
            p_lo_d  = ac_q;
          end else begin
            done_d = 1'b1;
            if (alu_wr) begin
              ac_d    = alu_r;
              flags_d = {alu_r == '0, alu_r[M],
                         alu_c, alu_v};
            end
          end
        end
      end
      S_MUL: begin
        p_hi_d = p_hi_n;
        p_lo_d = p_lo_n;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d  = S_IDLE;
          ac_d     = p_lo_n;
          mul_hi_d = p_hi_n;
          done_d   = 1'b1;
          flags_d  = {({p_hi_n, p_lo_n} == '0),
                      p_hi_n[M],
                      p_hi_n != '0,
                      p_hi_n != '0};
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      ac_q     <= '0;
      mul_hi_q <= '0;
      flags_q  <= '0;
      done_q   <= 1'b0;
      cnt_q    <= '0;
      mcand_q  <= '0;
      p_hi_q   <= '0;
      p_lo_q   <= '0;
    end else begin
      state_q  <= state_d;
      ac_q     <= ac_d;
      mul_hi_q <= mul_hi_d;
      flags_q  <= flags_d;
      done_q   <= done_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      p_hi_q   <= p_hi_d;
      p_lo_q   <= p_lo_d;
    end
  end

endmodule
